// File: rtl/seg_pkg.sv
// Shared symbol codes, sizes and conversion FSM state for the display front-end.
package seg_pkg;

    localparam logic [3:0] SYM_MINUS   = 4'd10;
    localparam logic [3:0] SYM_BLANK   = 4'd11;

    localparam int NUM_SYMBOLS = 6;
    localparam int NUM_ANODES  = 4;
    localparam int BCD_DIGITS  = 5;
    localparam int BCD_W       = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } conv_state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift,
    // so the shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per clock.
// start is only honoured in IDLE; the result is valid while done is high.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int ITER_W = $clog2(BIN_W);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

    conv_state_t state, state_nxt;

    logic [BIN_W-1:0]        bin_sr;
    logic [BCD_W-1:0]        acc;
    logic [ITER_W-1:0]       iter;
    logic [BCD_W+BIN_W-1:0]  shifted;

    // One double-dabble step: correct digits, then shift {bcd, bin} left by one
    always_comb begin
        shifted = {dd_adjust(acc), bin_sr} << 1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: run exactly BIN_W iterations, then a single result cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CONV;
            CONV: if (iter == LAST_ITER) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operand on start, then iterate while converting
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr <= '0;
            acc    <= '0;
            iter   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        acc    <= '0;
                        iter   <= '0;
                    end
                end
                CONV: begin
                    {acc, bin_sr} <= shifted;
                    iter          <= iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = acc;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment front-end: converts a signed value to sign + 5 BCD digits and
// scans a scrollable 4-symbol window of that result across the anodes.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int VALUE_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    input  logic               scroll_left,
    input  logic               scroll_right,
    output logic               busy,
    output logic [1:0]         en,
    output logic [3:0]         num
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       OFF_MAX = 2'(NUM_SYMBOLS - NUM_ANODES);

    logic               start;
    logic [VALUE_W-1:0] mag;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    logic               neg_q;
    logic [BCD_W-1:0]   digits;
    logic [3:0]         sign_sym;
    logic [1:0]         offset;
    logic [CNT_W-1:0]   refresh_cnt;
    logic [2:0]         sym_idx;

    // Loads during a conversion are dropped; the engine ignores start when busy.
    // Two's-complement negate of 0x8000 gives 0x8000 = 32768 unsigned, which is
    // exactly the magnitude wanted.
    assign start = load & ~busy;
    assign mag   = value[VALUE_W-1] ? (~value + 1'b1) : value;

    bin2bcd_seq #(
        .BIN_W (VALUE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (mag),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Sign follows the accepted load; display registers change only on the
    // done cycle so the scan never sees a partial conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q    <= 1'b0;
            digits   <= '0;
            sign_sym <= SYM_BLANK;
        end else begin
            if (start)
                neg_q <= value[VALUE_W-1];
            if (conv_done) begin
                digits   <= conv_bcd;
                sign_sym <= neg_q ? SYM_MINUS : SYM_BLANK;
            end
        end
    end

    // Window offset: saturating scroll, simultaneous pulses cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            offset <= '0;
        end else if (scroll_left && !scroll_right) begin
            if (offset != OFF_MAX)
                offset <= offset + 1'b1;
        end else if (scroll_right && !scroll_left) begin
            if (offset != 2'd0)
                offset <= offset - 1'b1;
        end
    end

    // Refresh divider: advance to the next anode slot at terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            en          <= '0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            en          <= en + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Slot en=k shows symbol offset+3-k, so slot 0 is the most significant
    assign sym_idx = 3'(offset) + 3'd3 - 3'(en);

    // Symbol select: index 5 is the sign, 4..0 are the decimal digits
    always_comb begin
        num = SYM_BLANK;
        case (sym_idx)
            3'd5:    num = sign_sym;
            3'd4:    num = digits[19:16];
            3'd3:    num = digits[15:12];
            3'd2:    num = digits[11:8];
            3'd1:    num = digits[7:4];
            3'd0:    num = digits[3:0];
            default: num = SYM_BLANK;
        endcase
    end

endmodule
